hamming_decoder: RTL and testbench

Pipelined SEC-DED decoder for the 11-bit data / 5-bit check-bit Hamming code used in the processor's protection path. It checks each received codeword, corrects any single-bit error, flags double-bit errors, and keeps saturating event counters for the fault-monitoring logic. It sits on the read side of protected storage, opposite the encoder, and consumes the stored data bits with their stored check bits.

---
 rtl/hamming_decoder.sv | 159 +++++++++++++++
 tb/tb_hamming_decoder.sv | 299 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hamming_decoder.sv
// hamming_decoder: two-stage SEC-DED decoder for 11 data bits + 5 check bits.
// Stage 1 captures the received word with its syndrome and overall parity.
// Stage 2 applies the correction, classifies the word and feeds the
// saturating event counters and the sticky double-error flag.
//
// Handshake: dec_valid_in qualifies dec_data_in/dec_parity_in in the cycle it
// is high; dec_valid_out qualifies dec_data_out, syndrome_out, sec_err and
// ded_err. There is no backpressure, so every accepted word emerges exactly
// two rising edges later.
module hamming_decoder #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rstN,
    input  logic             dec_valid_in,
    input  logic [10:0]      dec_data_in,
    input  logic [4:0]       dec_parity_in,
    input  logic             cnt_clr,
    output logic             dec_valid_out,
    output logic [10:0]      dec_data_out,
    output logic             sec_err,
    output logic             ded_err,
    output logic [3:0]       syndrome_out,
    output logic             ded_sticky,
    output logic [CNT_W-1:0] corr_count,
    output logic [CNT_W-1:0] uncorr_count
);

    // Stage 1 state
    logic             s1_valid_q, s1_valid_d;
    logic [10:0]      s1_data_q,  s1_data_d;
    logic [3:0]       s1_syn_q,   s1_syn_d;
    logic             s1_ovr_q,   s1_ovr_d;

    // Stage 2 state
    logic             out_valid_q, out_valid_d;
    logic [10:0]      out_data_q,  out_data_d;
    logic             out_sec_q,   out_sec_d;
    logic             out_ded_q,   out_ded_d;
    logic [3:0]       out_syn_q,   out_syn_d;
    logic             sticky_q,    sticky_d;
    logic [CNT_W-1:0] corr_q,      corr_d;
    logic [CNT_W-1:0] uncorr_q,    uncorr_d;

    logic [3:0]       chk;
    logic [10:0]      flip_mask;

    // Stage 1: recompute check bits, form syndrome and overall parity
    always_comb begin
        chk[0] = dec_data_in[0] ^ dec_data_in[1] ^ dec_data_in[3] ^ dec_data_in[4]
               ^ dec_data_in[6] ^ dec_data_in[8] ^ dec_data_in[10];
        chk[1] = dec_data_in[0] ^ dec_data_in[2] ^ dec_data_in[3] ^ dec_data_in[5]
               ^ dec_data_in[6] ^ dec_data_in[9] ^ dec_data_in[10];
        chk[2] = dec_data_in[1] ^ dec_data_in[2] ^ dec_data_in[3] ^ dec_data_in[7]
               ^ dec_data_in[8] ^ dec_data_in[9] ^ dec_data_in[10];
        chk[3] = dec_data_in[4] ^ dec_data_in[5] ^ dec_data_in[6] ^ dec_data_in[7]
               ^ dec_data_in[8] ^ dec_data_in[9] ^ dec_data_in[10];

        s1_valid_d = dec_valid_in;
        s1_data_d  = s1_data_q;
        s1_syn_d   = s1_syn_q;
        s1_ovr_d   = s1_ovr_q;
        if (dec_valid_in) begin
            s1_data_d = dec_data_in;
            s1_syn_d  = chk ^ dec_parity_in[3:0];
            s1_ovr_d  = (^dec_data_in) ^ (^dec_parity_in);
        end
    end

    // Syndrome to data-bit position; check-bit syndromes map to no data bit
    always_comb begin
        flip_mask = '0;
        case (s1_syn_q)
            4'd3:    flip_mask = 11'b000_0000_0001;
            4'd5:    flip_mask = 11'b000_0000_0010;
            4'd6:    flip_mask = 11'b000_0000_0100;
            4'd7:    flip_mask = 11'b000_0000_1000;
            4'd9:    flip_mask = 11'b000_0001_0000;
            4'd10:   flip_mask = 11'b000_0010_0000;
            4'd11:   flip_mask = 11'b000_0100_0000;
            4'd12:   flip_mask = 11'b000_1000_0000;
            4'd13:   flip_mask = 11'b001_0000_0000;
            4'd14:   flip_mask = 11'b010_0000_0000;
            4'd15:   flip_mask = 11'b100_0000_0000;
            default: flip_mask = '0;
        endcase
    end

    // Stage 2: classify, correct, and update counters and sticky flag
    always_comb begin
        out_valid_d = s1_valid_q;
        // Odd overall parity means one flipped bit; even parity with a
        // nonzero syndrome means two.
        out_sec_d   = s1_valid_q & s1_ovr_q;
        out_ded_d   = s1_valid_q & ~s1_ovr_q & (|s1_syn_q);
        out_data_d  = out_data_q;
        out_syn_d   = out_syn_q;
        if (s1_valid_q) begin
            out_syn_d  = s1_syn_q;
            out_data_d = s1_ovr_q ? (s1_data_q ^ flip_mask) : s1_data_q;
        end

        corr_d   = corr_q;
        uncorr_d = uncorr_q;
        sticky_d = sticky_q | out_ded_d;
        if (cnt_clr) begin
            // A clear coinciding with an event leaves that event counted.
            corr_d   = out_sec_d ? CNT_W'(1) : '0;
            uncorr_d = out_ded_d ? CNT_W'(1) : '0;
            sticky_d = out_ded_d;
        end else begin
            if (out_sec_d && !(&corr_q))
                corr_d = corr_q + CNT_W'(1);
            if (out_ded_d && !(&uncorr_q))
                uncorr_d = uncorr_q + CNT_W'(1);
        end
    end

    // Pipeline and counter registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rstN) begin
            s1_valid_q  <= 1'b0;
            s1_data_q   <= '0;
            s1_syn_q    <= '0;
            s1_ovr_q    <= 1'b0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_sec_q   <= 1'b0;
            out_ded_q   <= 1'b0;
            out_syn_q   <= '0;
            sticky_q    <= 1'b0;
            corr_q      <= '0;
            uncorr_q    <= '0;
        end else begin
            s1_valid_q  <= s1_valid_d;
            s1_data_q   <= s1_data_d;
            s1_syn_q    <= s1_syn_d;
            s1_ovr_q    <= s1_ovr_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_sec_q   <= out_sec_d;
            out_ded_q   <= out_ded_d;
            out_syn_q   <= out_syn_d;
            sticky_q    <= sticky_d;
            corr_q      <= corr_d;
            uncorr_q    <= uncorr_d;
        end
    end

    assign dec_valid_out = out_valid_q;
    assign dec_data_out  = out_data_q;
    assign sec_err       = out_sec_q;
    assign ded_err       = out_ded_q;
    assign syndrome_out  = out_syn_q;
    assign ded_sticky    = sticky_q;
    assign corr_count    = corr_q;
    assign uncorr_count  = uncorr_q;

endmodule

// File: tb/tb_hamming_decoder.sv
// Directed testbench for hamming_decoder. Inputs change on the falling edge,
// outputs are sampled on the falling edge, halfway between rising edges.
module tb_hamming_decoder;

  logic        clk;
  logic        rstN;
  logic        dec_valid_in;
  logic [10:0] dec_data_in;
  logic [4:0]  dec_parity_in;
  logic        cnt_clr;

  logic        dec_valid_out;
  logic [10:0] dec_data_out;
  logic        sec_err;
  logic        ded_err;
  logic [3:0]  syndrome_out;
  logic        ded_sticky;
  logic [15:0] corr_count;
  logic [15:0] uncorr_count;

  logic        n_valid_out;
  logic [10:0] n_data_out;
  logic        n_sec_err;
  logic        n_ded_err;
  logic [3:0]  n_syndrome_out;
  logic        n_ded_sticky;
  logic [1:0]  n_corr_count;
  logic [1:0]  n_uncorr_count;

  int n_checks;
  int n_pass;

  hamming_decoder #(.CNT_W(16)) dut (
    .clk           (clk),
    .rstN          (rstN),
    .dec_valid_in  (dec_valid_in),
    .dec_data_in   (dec_data_in),
    .dec_parity_in (dec_parity_in),
    .cnt_clr       (cnt_clr),
    .dec_valid_out (dec_valid_out),
    .dec_data_out  (dec_data_out),
    .sec_err       (sec_err),
    .ded_err       (ded_err),
    .syndrome_out  (syndrome_out),
    .ded_sticky    (ded_sticky),
    .corr_count    (corr_count),
    .uncorr_count  (uncorr_count)
  );

  // Narrow-counter instance sharing the same stimulus
  hamming_decoder #(.CNT_W(2)) dut_narrow (
    .clk           (clk),
    .rstN          (rstN),
    .dec_valid_in  (dec_valid_in),
    .dec_data_in   (dec_data_in),
    .dec_parity_in (dec_parity_in),
    .cnt_clr       (cnt_clr),
    .dec_valid_out (n_valid_out),
    .dec_data_out  (n_data_out),
    .sec_err       (n_sec_err),
    .ded_err       (n_ded_err),
    .syndrome_out  (n_syndrome_out),
    .ded_sticky    (n_ded_sticky),
    .corr_count    (n_corr_count),
    .uncorr_count  (n_uncorr_count)
  );

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic clear_counters();
    @(negedge clk);
    cnt_clr = 1'b1;
    @(negedge clk);
    cnt_clr = 1'b0;
  endtask

  task automatic test_reset();
    rstN = 1'b0;
    dec_valid_in = 1'b0;
    dec_data_in = '0;
    dec_parity_in = '0;
    cnt_clr = 1'b0;
    repeat (3) @(negedge clk);
    n_checks++;
    if ({dec_valid_out, sec_err, ded_err, ded_sticky} !== 4'b0000)
      $display("FAIL reset_flags: got %b expected 0000", {dec_valid_out, sec_err, ded_err, ded_sticky});
    else n_pass++;
    n_checks++;
    if ({dec_data_out, syndrome_out} !== 15'h0)
      $display("FAIL reset_data_syn: got %h expected 0000", {dec_data_out, syndrome_out});
    else n_pass++;
    n_checks++;
    if ({corr_count, uncorr_count} !== 32'h0)
      $display("FAIL reset_counts: got %h expected 00000000", {corr_count, uncorr_count});
    else n_pass++;
    rstN = 1'b1;
    @(negedge clk);
    n_checks++;
    if (dec_valid_out !== 1'b0)
      $display("FAIL reset_release_valid: got %b expected 0", dec_valid_out);
    else n_pass++;
  endtask

  task automatic test_clean();
    @(negedge clk);
    dec_valid_in = 1'b1; dec_data_in = 11'h000; dec_parity_in = 5'b00000;
    @(negedge clk);
    dec_valid_in = 1'b1; dec_data_in = 11'h7FF; dec_parity_in = 5'b11111;
    @(negedge clk);
    dec_valid_in = 1'b0;
    n_checks++;
    if ({dec_valid_out, dec_data_out, sec_err, ded_err, syndrome_out} !== {1'b1, 11'h000, 1'b0, 1'b0, 4'd0})
      $display("FAIL clean_zero: got v=%b d=%h sec=%b ded=%b s=%0d expected v=1 d=000 sec=0 ded=0 s=0",
               dec_valid_out, dec_data_out, sec_err, ded_err, syndrome_out);
    else n_pass++;
    @(negedge clk);
    n_checks++;
    if ({dec_valid_out, dec_data_out, sec_err, ded_err, syndrome_out} !== {1'b1, 11'h7FF, 1'b0, 1'b0, 4'd0})
      $display("FAIL clean_ones: got v=%b d=%h sec=%b ded=%b s=%0d expected v=1 d=7ff sec=0 ded=0 s=0",
               dec_valid_out, dec_data_out, sec_err, ded_err, syndrome_out);
    else n_pass++;
    @(negedge clk);
    n_checks++;
    if ({dec_valid_out, sec_err, ded_err, dec_data_out} !== {3'b000, 11'h7FF})
      $display("FAIL clean_idle_hold: got v=%b sec=%b ded=%b d=%h expected v=0 sec=0 ded=0 d=7ff",
               dec_valid_out, sec_err, ded_err, dec_data_out);
    else n_pass++;
    n_checks++;
    if (corr_count !== 16'd0)
      $display("FAIL clean_corr_count: got %0d expected 0", corr_count);
    else n_pass++;
  endtask

  task automatic test_single_data();
    @(negedge clk);
    dec_valid_in = 1'b1; dec_data_in = 11'h000; dec_parity_in = 5'b10011;
    @(negedge clk);
    dec_valid_in = 1'b0;
    @(negedge clk);
    n_checks++;
    if ({dec_valid_out, dec_data_out, sec_err, ded_err, syndrome_out} !== {1'b1, 11'h001, 1'b1, 1'b0, 4'd3})
      $display("FAIL single_data: got v=%b d=%h sec=%b ded=%b s=%0d expected v=1 d=001 sec=1 ded=0 s=3",
               dec_valid_out, dec_data_out, sec_err, ded_err, syndrome_out);
    else n_pass++;
    n_checks++;
    if ({corr_count, uncorr_count} !== {16'd1, 16'd0})
      $display("FAIL single_data_counts: got corr=%0d uncorr=%0d expected corr=1 uncorr=0", corr_count, uncorr_count);
    else n_pass++;
  endtask

  task automatic test_check_bit();
    @(negedge clk);
    dec_valid_in = 1'b1; dec_data_in = 11'h000; dec_parity_in = 5'b10000;
    @(negedge clk);
    dec_valid_in = 1'b0;
    @(negedge clk);
    n_checks++;
    if ({dec_valid_out, dec_data_out, sec_err, ded_err, syndrome_out} !== {1'b1, 11'h000, 1'b1, 1'b0, 4'd0})
      $display("FAIL check_bit_p4: got v=%b d=%h sec=%b ded=%b s=%0d expected v=1 d=000 sec=1 ded=0 s=0",
               dec_valid_out, dec_data_out, sec_err, ded_err, syndrome_out);
    else n_pass++;
    n_checks++;
    if (corr_count !== 16'd2)
      $display("FAIL check_bit_count: got %0d expected 2", corr_count);
    else n_pass++;
  endtask

  task automatic test_double();
    @(negedge clk);
    dec_valid_in = 1'b1; dec_data_in = 11'h002; dec_parity_in = 5'b10011;
    @(negedge clk);
    dec_valid_in = 1'b0;
    @(negedge clk);
    n_checks++;
    if ({dec_valid_out, dec_data_out, sec_err, ded_err, syndrome_out} !== {1'b1, 11'h002, 1'b0, 1'b1, 4'd6})
      $display("FAIL double: got v=%b d=%h sec=%b ded=%b s=%0d expected v=1 d=002 sec=0 ded=1 s=6",
               dec_valid_out, dec_data_out, sec_err, ded_err, syndrome_out);
    else n_pass++;
    n_checks++;
    if ({ded_sticky, uncorr_count, corr_count} !== {1'b1, 16'd1, 16'd2})
      $display("FAIL double_counts: got sticky=%b uncorr=%0d corr=%0d expected sticky=1 uncorr=1 corr=2",
               ded_sticky, uncorr_count, corr_count);
    else n_pass++;
    @(negedge clk);
    n_checks++;
    if ({ded_err, ded_sticky} !== 2'b01)
      $display("FAIL double_sticky_hold: got ded=%b sticky=%b expected ded=0 sticky=1", ded_err, ded_sticky);
    else n_pass++;
  endtask

  task automatic test_back_to_back();
    logic [10:0] w_data [5];
    logic [4:0]  w_par  [5];
    logic [10:0] w_exp  [5];
    logic [3:0]  w_syn  [5];
    int          exp_corr;
    w_data[0] = 11'h000; w_par[0] = 5'b10011; w_exp[0] = 11'h001; w_syn[0] = 4'd3;
    w_data[1] = 11'h400; w_par[1] = 5'b00000; w_exp[1] = 11'h000; w_syn[1] = 4'd15;
    w_data[2] = 11'h020; w_par[2] = 5'b00000; w_exp[2] = 11'h000; w_syn[2] = 4'd10;
    w_data[3] = 11'h000; w_par[3] = 5'b00100; w_exp[3] = 11'h000; w_syn[3] = 4'd4;
    w_data[4] = 11'h000; w_par[4] = 5'b10000; w_exp[4] = 11'h000; w_syn[4] = 4'd0;
    clear_counters();
    n_checks++;
    if ({ded_sticky, corr_count, uncorr_count} !== 33'h0)
      $display("FAIL clear_all: got sticky=%b corr=%0d uncorr=%0d expected 0 0 0", ded_sticky, corr_count, uncorr_count);
    else n_pass++;
    for (int i = 0; i < 7; i++) begin
      @(negedge clk);
      cnt_clr = (i == 5);
      if (i < 5) begin
        dec_valid_in = 1'b1; dec_data_in = w_data[i]; dec_parity_in = w_par[i];
      end else begin
        dec_valid_in = 1'b0;
      end
      if (i >= 2) begin
        exp_corr = (i == 6) ? 1 : i - 1;
        n_checks++;
        if ({dec_valid_out, dec_data_out, sec_err, ded_err, syndrome_out} !== {1'b1, w_exp[i-2], 1'b1, 1'b0, w_syn[i-2]})
          $display("FAIL b2b_word%0d: got v=%b d=%h sec=%b ded=%b s=%0d expected v=1 d=%h sec=1 ded=0 s=%0d",
                   i - 2, dec_valid_out, dec_data_out, sec_err, ded_err, syndrome_out, w_exp[i-2], w_syn[i-2]);
        else n_pass++;
        n_checks++;
        if (corr_count !== 16'(exp_corr))
          $display("FAIL b2b_corr%0d: got %0d expected %0d", i - 2, corr_count, exp_corr);
        else n_pass++;
      end
    end
  endtask

  task automatic test_saturation();
    clear_counters();
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      dec_valid_in = 1'b1; dec_data_in = 11'h000; dec_parity_in = 5'b10000;
    end
    @(negedge clk);
    dec_valid_in = 1'b0;
    n_checks++;
    if (n_corr_count !== 2'd3)
      $display("FAIL sat_reach: got %0d expected 3", n_corr_count);
    else n_pass++;
    repeat (2) @(negedge clk);
    n_checks++;
    if (n_corr_count !== 2'd3)
      $display("FAIL sat_hold: got %0d expected 3", n_corr_count);
    else n_pass++;
    n_checks++;
    if ({corr_count, n_uncorr_count} !== {16'd5, 2'd0})
      $display("FAIL sat_wide: got corr=%0d narrow_uncorr=%0d expected corr=5 narrow_uncorr=0", corr_count, n_uncorr_count);
    else n_pass++;
  endtask

  task automatic test_reset_midstream();
    @(negedge clk);
    dec_valid_in = 1'b1; dec_data_in = 11'h002; dec_parity_in = 5'b10011;
    @(negedge clk);
    dec_valid_in = 1'b1; dec_data_in = 11'h000; dec_parity_in = 5'b10011;
    @(negedge clk);
    dec_valid_in = 1'b0;
    rstN = 1'b0;
    @(negedge clk);
    n_checks++;
    if ({dec_valid_out, dec_data_out, sec_err, ded_err, syndrome_out, ded_sticky} !== 19'h0)
      $display("FAIL midrst_outputs: got v=%b d=%h sec=%b ded=%b s=%0d sticky=%b expected all 0",
               dec_valid_out, dec_data_out, sec_err, ded_err, syndrome_out, ded_sticky);
    else n_pass++;
    n_checks++;
    if ({corr_count, uncorr_count} !== 32'h0)
      $display("FAIL midrst_counts: got corr=%0d uncorr=%0d expected 0 0", corr_count, uncorr_count);
    else n_pass++;
    rstN = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      n_checks++;
      if ({dec_valid_out, sec_err, ded_err} !== 3'b000)
        $display("FAIL midrst_stale%0d: got v=%b sec=%b ded=%b expected 0 0 0", i, dec_valid_out, sec_err, ded_err);
      else n_pass++;
    end
  endtask

  initial begin
    n_checks = 0;
    n_pass = 0;
    test_reset();
    clear_counters();
    test_clean();
    test_single_data();
    test_check_bit();
    test_double();
    test_back_to_back();
    test_saturation();
    test_reset_midstream();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
